// File: rtl/memory_stage_if.sv
// Handshake and data bundle between the processor sequencer and the memory stage.
interface memory_stage_if;
    logic        mem_start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [2:0]  stat_in;
    logic        busy;
    logic        mem_done;
    logic [63:0] valM;
    logic [2:0]  stat;
    logic        dmem_error;

    modport master (
        output mem_start, icode, valE, valA, valP, stat_in,
        input  busy, mem_done, valM, stat, dmem_error
    );

    modport slave (
        input  mem_start, icode, valE, valA, valP, stat_in,
        output busy, mem_done, valM, stat, dmem_error
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: multi-cycle 8-byte little-endian access to an internal
// byte array, with start/done handshake and final status resolution.
module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int ACC_LAT   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [2:0]  stat;
    } req_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    req_t          req_q;
    logic          acc_fire;

    logic [63:0]   valM_q;
    logic [2:0]    stat_q;
    logic          err_q;

    logic          rd, wr, fault, up_ok;
    logic [63:0]   addr, wdata, rdata;
    logic [AW-1:0] idx;

    logic [7:0]    mem [MEM_BYTES];

    always_comb begin
        state_d      = state_q;
        acc_fire     = 1'b0;
        bus.busy     = (state_q != IDLE);
        bus.mem_done = 1'b0;
        case (state_q)
            IDLE:   if (bus.mem_start) state_d = ACCESS;
            ACCESS: if (cnt_q == '0) begin
                        acc_fire = 1'b1;
                        state_d  = DONE;
                    end
            DONE:   begin
                        bus.mem_done = 1'b1;
                        state_d      = IDLE;
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.mem_start) begin
                cnt_q <= CW'(ACC_LAT - 1);
                req_q <= '{bus.icode, bus.valE, bus.valA, bus.valP, bus.stat_in};
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // ret/popq address through valA; everything else that touches memory uses valE
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = req_q.valE;
        wdata = req_q.valA;
        case (req_q.icode)
            4'h4, 4'hA: wr = 1'b1;
            4'h8:       begin wr = 1'b1; wdata = req_q.valP; end
            4'h5:       rd = 1'b1;
            4'h9, 4'hB: begin rd = 1'b1; addr = req_q.valA; end
            default:    ;
        endcase
        up_ok = (req_q.stat == SAOK);
        fault = (rd | wr) && (addr > 64'(MEM_BYTES - 8));
        idx   = addr[AW-1:0];
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++)
            rdata[8*k +: 8] = mem[idx + AW'(k)];
    end

    // Array is deliberately left out of reset; a reset on the access edge blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && acc_fire && wr && up_ok && !fault)
            for (int k = 0; k < 8; k++)
                mem[idx + AW'(k)] <= wdata[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valM_q <= '0;
            stat_q <= SAOK;
            err_q  <= 1'b0;
        end else if (acc_fire) begin
            if (!up_ok) begin
                valM_q <= '0;
                stat_q <= req_q.stat;
                err_q  <= 1'b0;
            end else if (fault) begin
                valM_q <= '0;
                stat_q <= SADR;
                err_q  <= 1'b1;
            end else begin
                valM_q <= rd ? rdata : 64'd0;
                stat_q <= SAOK;
                err_q  <= 1'b0;
            end
        end
    end

    assign bus.valM       = valM_q;
    assign bus.stat       = stat_q;
    assign bus.dmem_error = err_q;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected responses, a
// negedge monitor pops and compares on every mem_done.
module tb_memory_stage;
    localparam int MEM_BYTES = 1024;
    localparam int ACC_LAT   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_stage_if bus();

    memory_stage #(.MEM_BYTES(MEM_BYTES), .ACC_LAT(ACC_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] valM;
        logic [2:0]  stat;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_done === 1'b1) begin
            chk("done_width", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got mem_done=1, expected no response");
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".valM"}, bus.valM, e.valM);
                chk({e.tag, ".stat"}, 64'(bus.stat), 64'(e.stat));
                chk({e.tag, ".dmem_error"}, 64'(bus.dmem_error), 64'(e.err));
            end
        end
        prev_done = bus.mem_done;
    end

    // One request from an idle cycle; returns one cycle after DONE with the FSM idle.
    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input logic [2:0] st,
                         input logic [63:0] xm, input logic [2:0] xs, input logic xe,
                         input string tag, input bit noisy = 1'b0);
        int lat;
        sb.push_back('{xm, xs, xe, tag});
        bus.icode     = ic;
        bus.valE      = e;
        bus.valA      = a;
        bus.valP      = p;
        bus.stat_in   = st;
        bus.mem_start = 1'b1;
        @(posedge clk); #1;
        bus.mem_start = 1'b0;
        lat = 1;
        chk({tag, ".busy_rise"}, 64'(bus.busy), 64'd1);
        while (bus.mem_done !== 1'b1 && lat < 20) begin
            if (noisy) begin
                bus.mem_start = 1'b1;
                bus.icode     = 4'h4;
                bus.valE      = 64'h100;
                bus.valA      = 64'h5555;
                bus.stat_in   = 3'd1;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(ACC_LAT + 1));
        @(posedge clk); #1;
        bus.mem_start = 1'b0;
        chk({tag, ".busy_fall"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises[$];
        logic pb;
        bus.mem_start = 1'b0;
        bus.icode     = 4'h0;
        bus.valE      = '0;
        bus.valA      = '0;
        bus.valP      = '0;
        bus.stat_in   = 3'd1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.mem_done", 64'(bus.mem_done), 64'd0);
        chk("rst.valM", bus.valM, 64'd0);
        chk("rst.stat", 64'(bus.stat), 64'd1);
        chk("rst.dmem_error", 64'(bus.dmem_error), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write/read round trip, byte order, unaligned
        issue(4'h4, 64'h08, 64'h0, 0, 1, 64'h0, 1, 0, "wr_zero_08");
        issue(4'h4, 64'h10, 64'h1122334455667788, 0, 1, 64'h0, 1, 0, "wr_10");
        issue(4'h5, 64'h10, 0, 0, 1, 64'h1122334455667788, 1, 0, "rd_10");
        issue(4'h5, 64'h0F, 0, 0, 1, 64'h2233445566778800, 1, 0, "rd_unaligned_0F");

        // call/ret, push/pop
        issue(4'h8, 64'h100, 0, 64'h2A, 1, 64'h0, 1, 0, "call");
        issue(4'h9, 64'h0, 64'h100, 0, 1, 64'h2A, 1, 0, "ret");
        issue(4'hB, 64'h0, 64'h100, 0, 1, 64'h2A, 1, 0, "popq");
        issue(4'hA, 64'h108, 64'hDEAD, 0, 1, 64'h0, 1, 0, "pushq");
        issue(4'h5, 64'h108, 0, 0, 1, 64'hDEAD, 1, 0, "rd_108");

        // address boundary; the negative address aliases 1016 if not suppressed
        issue(4'h4, 64'd1016, 64'hCAFEBABE0BADF00D, 0, 1, 64'h0, 1, 0, "wr_1016");
        issue(4'h5, 64'd1016, 0, 0, 1, 64'hCAFEBABE0BADF00D, 1, 0, "rd_1016");
        issue(4'h5, 64'd1017, 0, 0, 1, 64'h0, 3, 1, "rd_1017");
        issue(4'h4, 64'hFFFFFFFFFFFFFFF8, 64'h1234, 0, 1, 64'h0, 3, 1, "wr_neg");
        issue(4'h5, 64'd1016, 0, 0, 1, 64'hCAFEBABE0BADF00D, 1, 0, "rd_1016_again");

        // upstream status wins over everything
        issue(4'h4, 64'h20, 64'h0123456789ABCDEF, 0, 1, 64'h0, 1, 0, "wr_20");
        issue(4'h4, 64'h20, 64'hFFFF, 0, 4, 64'h0, 4, 0, "sins_wr_20");
        issue(4'h5, 64'h20, 0, 0, 1, 64'h0123456789ABCDEF, 1, 0, "rd_20");
        issue(4'h5, 64'd1017, 0, 0, 2, 64'h0, 2, 0, "shlt_fault");

        // nop, and starts while busy (including DONE) ignored
        issue(4'h1, 64'h10, 64'h10, 0, 1, 64'h0, 1, 0, "nop");
        issue(4'h5, 64'h100, 0, 0, 1, 64'h2A, 1, 0, "busy_ignore", 1'b1);
        issue(4'h9, 64'h0, 64'h100, 0, 1, 64'h2A, 1, 0, "rd_100_after_ignore");

        // mem_start held high: accepts in cycles 0, 4, 8 -> busy rises in 1, 5, 9
        for (int i = 0; i < 3; i++) sb.push_back('{64'h0, 3'd1, 1'b0, "hold_nop"});
        bus.icode     = 4'h1;
        bus.stat_in   = 3'd1;
        bus.mem_start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            pb = bus.busy;
            @(posedge clk); #1;
            if (bus.busy && !pb) rises.push_back(c + 1);
        end
        bus.mem_start = 1'b0;
        chk("hold.accepts", 64'(rises.size()), 64'd3);
        if (rises.size() == 3) begin
            chk("hold.first", 64'(rises[0]), 64'd1);
            chk("hold.gap1", 64'(rises[1] - rises[0]), 64'(ACC_LAT + 2));
            chk("hold.gap2", 64'(rises[2] - rises[1]), 64'(ACC_LAT + 2));
        end
        for (int c = 0; c < 10 && bus.busy; c++) begin
            @(posedge clk); #1;
        end
        chk("hold.idle", 64'(bus.busy), 64'd0);

        // reset on the access edge of a write to 0x40
        issue(4'h4, 64'h40, 64'hAAAA000000005555, 0, 1, 64'h0, 1, 0, "wr_40");
        issue(4'h5, 64'd1017, 0, 0, 1, 64'h0, 3, 1, "pre_rst_fault");
        bus.icode     = 4'h4;
        bus.valE      = 64'h40;
        bus.valA      = 64'hBBBB;
        bus.stat_in   = 3'd1;
        bus.mem_start = 1'b1;
        @(posedge clk); #1;
        bus.mem_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_acc.busy", 64'(bus.busy), 64'd0);
        chk("rst_acc.mem_done", 64'(bus.mem_done), 64'd0);
        chk("rst_acc.stat", 64'(bus.stat), 64'd1);
        chk("rst_acc.dmem_error", 64'(bus.dmem_error), 64'd0);
        chk("rst_acc.valM", bus.valM, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc.no_done", 64'(bus.mem_done), 64'd0);
        issue(4'h5, 64'h40, 0, 0, 1, 64'hAAAA000000005555, 1, 0, "rd_40");

        // start held during reset is never accepted
        bus.icode     = 4'h1;
        rst_n         = 1'b0;
        bus.mem_start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_start.busy", 64'(bus.busy), 64'd0);
        end
        rst_n         = 1'b1;
        bus.mem_start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start.after", 64'(bus.busy), 64'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
